// File: rtl/sram_bus_ctrl_pkg.sv
// Shared types and constants for the SRAM bus controller and its access sequencer.
package sram_bus_ctrl_pkg;

  localparam int REG_W = 32;
  localparam int BE_W  = 4;

  typedef enum logic [1:0] {
    SRAM_IDLE = 2'd0,
    SRAM_DATA = 2'd1,
    SRAM_INST = 2'd2,
    SRAM_HOLD = 2'd3
  } sram_state_e;

  localparam logic [BE_W-1:0] BE_NONE = 4'b1111;
  localparam logic [BE_W-1:0] BE_ALL  = 4'b0000;

  typedef struct packed {
    logic            ce_n;
    logic            oe_n;
    logic            we_n;
    logic [BE_W-1:0] be_n;
    logic            data_oe;
  } sram_strobe_t;

  localparam sram_strobe_t STROBE_IDLE = '{
    ce_n:    1'b1,
    oe_n:    1'b1,
    we_n:    1'b1,
    be_n:    BE_NONE,
    data_oe: 1'b0
  };

endpackage

// File: rtl/sram_bus_ctrl_access_seq.sv
// Wait-state counter and strobe generator for a single SRAM access.
// start_i is held high for every cycle of the access; done_o marks its last cycle.
module sram_access_seq
  import sram_bus_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            we_i,
  input  logic [BE_W-1:0] sel_i,
  output sram_strobe_t    strobe_o,
  output logic            capture_o,
  output logic            done_o
);

  localparam int CNT_W = (WAIT_STATES < 4) ? 2 : $clog2(WAIT_STATES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_cycle;
  logic             mid_cycle;

  assign last_cycle = (cnt_q == CNT_LAST);
  // Write pulse leaves one cycle of address/data setup before it and one of hold after it.
  assign mid_cycle  = (cnt_q != '0) && !last_cycle;
  assign done_o     = start_i && last_cycle;
  assign capture_o  = done_o && !we_i;

  // Counter advances only during an access and rewinds on its last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (!start_i || last_cycle) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Strobe decode for the current access cycle.
  always_comb begin
    strobe_o = STROBE_IDLE;
    if (start_i) begin
      strobe_o.ce_n = 1'b0;
      if (we_i) begin
        strobe_o.be_n    = ~sel_i;
        strobe_o.data_oe = 1'b1;
        strobe_o.we_n    = !mid_cycle;
      end else begin
        strobe_o.oe_n = 1'b0;
        strobe_o.be_n = BE_ALL;
      end
    end else begin
      strobe_o = STROBE_IDLE;
    end
  end

endmodule

// File: rtl/sram_bus_ctrl.sv
// Serves the core's instruction and data ports from one asynchronous SRAM,
// data port first, stalling the pipeline until both accesses of a cycle finish.
module sram_bus_ctrl
  import sram_bus_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [REG_W-1:0]  rom_addr_i,
  output logic [REG_W-1:0]  rom_data_o,
  input  logic              ram_ce_i,
  input  logic              ram_we_i,
  input  logic [BE_W-1:0]   ram_sel_i,
  input  logic [REG_W-1:0]  ram_addr_i,
  input  logic [REG_W-1:0]  ram_data_i,
  output logic [REG_W-1:0]  ram_data_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [REG_W-1:0]  sram_data_o,
  output logic              sram_data_oe_o,
  input  logic [REG_W-1:0]  sram_data_i,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [BE_W-1:0]   sram_be_n_o
);

  sram_state_e       state_q;
  sram_state_e       state_d;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] rom_addr_d;
  logic              ram_we_q;
  logic              ram_we_d;
  logic [BE_W-1:0]   ram_sel_q;
  logic [BE_W-1:0]   ram_sel_d;
  logic [REG_W-1:0]  ram_wdata_q;
  logic [REG_W-1:0]  ram_wdata_d;
  logic [REG_W-1:0]  rom_data_q;
  logic [REG_W-1:0]  rom_data_d;
  logic [REG_W-1:0]  ram_data_q;
  logic [REG_W-1:0]  ram_data_d;

  logic              in_idle;
  logic              in_data;
  logic              in_inst;
  logic              any_req;
  logic              acc_run;
  logic              acc_we;
  logic              acc_capture;
  logic              acc_done;
  sram_strobe_t      acc_strobe;
  logic              unused_addr_bits;

  assign in_idle = (state_q == SRAM_IDLE);
  assign in_data = (state_q == SRAM_DATA);
  assign in_inst = (state_q == SRAM_INST);
  assign any_req = ram_ce_i || rom_ce_i;
  assign acc_run = in_data || in_inst;
  assign acc_we  = in_data && ram_we_q;

  // Byte-offset and above-window address bits are intentionally dropped.
  assign unused_addr_bits = ^{rom_addr_i[REG_W-1:ADDR_W+2], rom_addr_i[1:0],
                              ram_addr_i[REG_W-1:ADDR_W+2], ram_addr_i[1:0]};

  sram_access_seq #(
    .WAIT_STATES(WAIT_STATES)
  ) u_access_seq (
    .clk       (clk),
    .rst       (rst),
    .start_i   (acc_run),
    .we_i      (acc_we),
    .sel_i     (ram_sel_q),
    .strobe_o  (acc_strobe),
    .capture_o (acc_capture),
    .done_o    (acc_done)
  );

  // Next-state: data access first, then an instruction fetch if one is pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SRAM_IDLE: begin
        if (ram_ce_i) begin
          state_d = SRAM_DATA;
        end else if (rom_ce_i) begin
          state_d = SRAM_INST;
        end else begin
          state_d = SRAM_IDLE;
        end
      end
      SRAM_DATA: begin
        if (acc_done) begin
          state_d = rom_ce_i ? SRAM_INST : SRAM_HOLD;
        end else begin
          state_d = SRAM_DATA;
        end
      end
      SRAM_INST: begin
        if (acc_done) begin
          state_d = SRAM_HOLD;
        end else begin
          state_d = SRAM_INST;
        end
      end
      SRAM_HOLD: state_d = SRAM_IDLE;
      default:   state_d = SRAM_IDLE;
    endcase
  end

  // Requests are sampled only when leaving IDLE; later input changes are ignored.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = ram_we_q;
    ram_sel_d   = ram_sel_q;
    ram_wdata_d = ram_wdata_q;
    rom_addr_d  = rom_addr_q;
    if (in_idle && ram_ce_i) begin
      ram_addr_d  = ram_addr_i[ADDR_W+1:2];
      ram_we_d    = ram_we_i;
      ram_sel_d   = ram_sel_i;
      ram_wdata_d = ram_data_i;
    end else begin
      ram_addr_d  = ram_addr_q;
    end
    if (in_idle && any_req) begin
      rom_addr_d = rom_addr_i[ADDR_W+1:2];
    end else begin
      rom_addr_d = rom_addr_q;
    end
  end

  // Read-data capture on the last cycle of a read; each port keeps its last word.
  always_comb begin
    rom_data_d = rom_data_q;
    ram_data_d = ram_data_q;
    if (acc_capture && in_inst) begin
      rom_data_d = sram_data_i;
    end else if (acc_capture && in_data) begin
      ram_data_d = sram_data_i;
    end else begin
      rom_data_d = rom_data_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SRAM_IDLE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_sel_q   <= '0;
      ram_wdata_q <= '0;
      rom_addr_q  <= '0;
      rom_data_q  <= '0;
      ram_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_sel_q   <= ram_sel_d;
      ram_wdata_q <= ram_wdata_d;
      rom_addr_q  <= rom_addr_d;
      rom_data_q  <= rom_data_d;
      ram_data_q  <= ram_data_d;
    end
  end

  // SRAM address follows whichever port owns the current access.
  always_comb begin
    case (state_q)
      SRAM_DATA: sram_addr_o = ram_addr_q;
      SRAM_INST: sram_addr_o = rom_addr_q;
      default:   sram_addr_o = '0;
    endcase
  end

  assign sram_data_o    = acc_we ? ram_wdata_q : '0;
  assign sram_data_oe_o = acc_strobe.data_oe;
  assign sram_ce_n_o    = acc_strobe.ce_n;
  assign sram_oe_n_o    = acc_strobe.oe_n;
  assign sram_we_n_o    = acc_strobe.we_n;
  assign sram_be_n_o    = acc_strobe.be_n;

  assign rom_data_o = rom_data_q;
  assign ram_data_o = ram_data_q;
  // HOLD drops the stall for one cycle so the pipeline advances.
  assign stallreq_o = (in_idle && any_req) || acc_run;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Randomized bench for sram_bus_ctrl: a per-cycle expected bus schedule is
// derived from each transaction and compared against the DUT every cycle.
module tb_sram_bus_ctrl;

  localparam int WS        = 2;
  localparam int AW        = 20;
  localparam int MEM_WORDS = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_ce_i;
  logic [31:0]   rom_addr_i;
  logic [31:0]   rom_data_o;
  logic          ram_ce_i;
  logic          ram_we_i;
  logic [3:0]    ram_sel_i;
  logic [31:0]   ram_addr_i;
  logic [31:0]   ram_data_i;
  logic [31:0]   ram_data_o;
  logic          stallreq_o;
  logic [AW-1:0] sram_addr_o;
  logic [31:0]   sram_data_o;
  logic          sram_data_oe_o;
  logic [31:0]   sram_data_i;
  logic          sram_ce_n_o;
  logic          sram_oe_n_o;
  logic          sram_we_n_o;
  logic [3:0]    sram_be_n_o;

  always #5 clk = ~clk;

  sram_bus_ctrl #(.WAIT_STATES(WS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
    .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_sel_i(ram_sel_i),
    .ram_addr_i(ram_addr_i), .ram_data_i(ram_data_i), .ram_data_o(ram_data_o),
    .stallreq_o(stallreq_o), .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o),
    .sram_data_oe_o(sram_data_oe_o), .sram_data_i(sram_data_i),
    .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
    .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o)
  );

  int total = 0;
  int bad   = 0;
  int last_stall = 0;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      4:       return 32'h2401_0005;
      5:       return 32'h1234_5678;
      64:      return 32'hDEAD_BEEF;
      128:     return 32'h1111_1111;
      default: return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Physical asynchronous SRAM driven by the DUT strobes.
  logic [31:0] sram_mem [MEM_WORDS];
  logic        mem_init;
  assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram_mem[sram_addr_o[9:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) sram_mem[i] <= init_word(i);
    end else if (!sram_ce_n_o && !sram_we_n_o) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n_o[b]) sram_mem[sram_addr_o[9:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
    end
  end

  // Reference model: memory image, last word per port, expected per-cycle bus.
  typedef struct {
    logic          stall;
    logic          ce_n;
    logic          oe_n;
    logic          we_n;
    logic [3:0]    be_n;
    logic [AW-1:0] addr;
    logic          doe;
    logic [31:0]   wdata;
    logic [31:0]   rom_d;
    logic [31:0]   ram_d;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] cur_rom;
  logic [31:0] cur_ram;

  task automatic push_idle(input logic stall);
    exp_t r;
    r.stall = stall; r.ce_n = 1'b1; r.oe_n = 1'b1; r.we_n = 1'b1; r.be_n = 4'b1111;
    r.addr = '0; r.doe = 1'b0; r.wdata = 32'h0; r.rom_d = cur_rom; r.ram_d = cur_ram;
    exp_q.push_back(r);
  endtask

  task automatic push_acc(input logic [AW-1:0] a, input logic we, input logic [3:0] sel,
                          input logic [31:0] wd);
    exp_t r;
    for (int k = 0; k <= WS; k++) begin
      r.stall = 1'b1; r.ce_n = 1'b0; r.addr = a; r.rom_d = cur_rom; r.ram_d = cur_ram;
      if (we) begin
        r.oe_n = 1'b1; r.we_n = (k > 0 && k < WS) ? 1'b0 : 1'b1;
        r.be_n = ~sel; r.doe = 1'b1; r.wdata = wd;
      end else begin
        r.oe_n = 1'b0; r.we_n = 1'b1; r.be_n = 4'b0000; r.doe = 1'b0; r.wdata = 32'h0;
      end
      exp_q.push_back(r);
    end
  endtask

  function automatic logic [AW-1:0] word_of(input logic [31:0] byte_addr);
    logic [31:0] w;
    w = (byte_addr >> 2) & ((32'h1 << AW) - 32'h1);
    return w[AW-1:0];
  endfunction

  task automatic run_txn(input logic rce, input logic ice, input logic we, input logic [3:0] sel,
                         input logic [31:0] raddr, input logic [31:0] wdata,
                         input logic [31:0] iaddr, input bit perturb);
    logic [AW-1:0] rw;
    logic [AW-1:0] iw;
    int            exp_stall;
    int            measured;
    bit            done;
    rw = word_of(raddr);
    iw = word_of(iaddr);
    ram_ce_i = rce; ram_we_i = we; ram_sel_i = sel; ram_addr_i = raddr; ram_data_i = wdata;
    rom_ce_i = ice; rom_addr_i = iaddr;
    if (!rce && !ice) begin
      push_idle(1'b0);
      exp_stall = 0;
    end else begin
      push_idle(1'b1);
      if (rce) begin
        push_acc(rw, we, sel, wdata);
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[rw[9:0]][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          cur_ram = ref_mem[rw[9:0]];
        end
      end
      if (ice) begin
        push_acc(iw, 1'b0, 4'b0000, 32'h0);
        cur_rom = ref_mem[iw[9:0]];
      end
      push_idle(1'b0);
      exp_stall = 1 + ((rce ? 1 : 0) + (ice ? 1 : 0)) * (WS + 1);
    end
    measured = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      #2;
      if (!stallreq_o) begin
        done = 1'b1;
      end else begin
        measured++;
        if (perturb && k == 2) begin
          ram_addr_i = $urandom; ram_data_i = $urandom; ram_sel_i = 4'($urandom);
        end
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL stall_timeout: stallreq_o still 1 after 40 cycles");
    end
    chk("stall_len", 32'(measured), 32'(exp_stall));
    last_stall = measured;
    @(posedge clk); #1;
  endtask

  // Per-cycle compare against the expected schedule, plus bus exclusivity rules.
  always @(negedge clk) begin
    if (!rst) begin
      chk("oe_we_both_low", 32'(!sram_oe_n_o && !sram_we_n_o), 32'h0);
      chk("doe_with_oe", 32'(sram_data_oe_o && !sram_oe_n_o), 32'h0);
    end
    if (exp_q.size() != 0) begin
      cur_e = exp_q.pop_front();
      chk("stallreq", 32'(stallreq_o), 32'(cur_e.stall));
      chk("ce_n", 32'(sram_ce_n_o), 32'(cur_e.ce_n));
      chk("oe_n", 32'(sram_oe_n_o), 32'(cur_e.oe_n));
      chk("we_n", 32'(sram_we_n_o), 32'(cur_e.we_n));
      chk("be_n", 32'(sram_be_n_o), 32'(cur_e.be_n));
      chk("sram_addr", 32'(sram_addr_o), 32'(cur_e.addr));
      chk("data_oe", 32'(sram_data_oe_o), 32'(cur_e.doe));
      if (cur_e.doe) chk("sram_wdata", sram_data_o, cur_e.wdata);
      chk("rom_data", rom_data_o, cur_e.rom_d);
      chk("ram_data", ram_data_o, cur_e.ram_d);
    end
  end

  task automatic chk_idle_lit(input string tag);
    chk({tag, "_stall"}, 32'(stallreq_o), 32'h0);
    chk({tag, "_ce_n"}, 32'(sram_ce_n_o), 32'h1);
    chk({tag, "_oe_n"}, 32'(sram_oe_n_o), 32'h1);
    chk({tag, "_we_n"}, 32'(sram_we_n_o), 32'h1);
    chk({tag, "_be_n"}, 32'(sram_be_n_o), 32'hF);
    chk({tag, "_addr"}, 32'(sram_addr_o), 32'h0);
    chk({tag, "_wdata"}, sram_data_o, 32'h0);
    chk({tag, "_doe"}, 32'(sram_data_oe_o), 32'h0);
    chk({tag, "_rom"}, rom_data_o, 32'h0);
    chk({tag, "_ram"}, ram_data_o, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mism;
    logic rce, ice, we;
    rst = 1'b1; mem_init = 1'b1;
    rom_ce_i = 1'b0; rom_addr_i = 32'h0; ram_ce_i = 1'b0; ram_we_i = 1'b0;
    ram_sel_i = 4'h0; ram_addr_i = 32'h0; ram_data_i = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    cur_rom = 32'h0; cur_ram = 32'h0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; mem_init = 1'b0;
    #2; chk_idle_lit("reset");
    @(posedge clk); #1;

    // Directed cases with hand-computed results.
    run_txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0000_0010, 1'b0);
    chk("fetch_word_lit", rom_data_o, 32'h2401_0005);
    chk("fetch_stall_lit", 32'(last_stall), 32'd4);
    run_txn(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h0000_0014, 1'b0);
    chk("dread_word_lit", ram_data_o, 32'hDEAD_BEEF);
    chk("dfetch_word_lit", rom_data_o, 32'h1234_5678);
    chk("dread_stall_lit", 32'(last_stall), 32'd7);
    run_txn(1'b1, 1'b0, 1'b1, 4'b0010, 32'h0000_0200, 32'h0000_AB00, 32'h0, 1'b1);
    chk("write_stall_lit", 32'(last_stall), 32'd4);
    run_txn(1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_0200, 32'h0, 32'h0, 1'b0);
    chk("byte_write_readback_lit", ram_data_o, 32'h1111_AB11);
    run_txn(1'b1, 1'b1, 1'b0, 4'h0, 32'hFFC0_0105, 32'h0, 32'h7FC0_0012, 1'b1);

    // Reset pulsed in the middle of a data access.
    ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = 32'h0000_0100; rom_ce_i = 1'b1;
    rom_addr_i = 32'h0000_0010;
    @(posedge clk); #2;
    chk("mid_rst_in_data", 32'(sram_ce_n_o), 32'h0);
    rst = 1'b1; ram_ce_i = 1'b0; rom_ce_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #2; chk_idle_lit("mid_rst");
    cur_rom = 32'h0; cur_ram = 32'h0;
    @(posedge clk); #1;

    // Randomized back-to-back pipeline cycles.
    for (int n = 0; n < 80; n++) begin
      rce = ($urandom_range(0, 3) != 0);
      ice = ($urandom_range(0, 3) != 0);
      we  = 1'($urandom_range(0, 1));
      run_txn(rce, ice, we, 4'($urandom),
              ($urandom & 32'hFFC0_0003) | (32'($urandom_range(0, 255)) << 2),
              $urandom,
              ($urandom & 32'hFFC0_0003) | (32'($urandom_range(0, 255)) << 2),
              1'b1);
    end

    ram_ce_i = 1'b0; rom_ce_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("schedule_drained", 32'(exp_q.size()), 32'h0);
    mism = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (sram_mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", 32'(mism), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_bus_ctrl.md
Name: sram_bus_ctrl

Overview:
- Sits directly below the CPU core. Serves both of the core's memory ports from one external asynchronous 32-bit SRAM:
  - instruction port: rom_addr / rom_ce / rom_data
  - data port: ram_addr / ram_data / ram_we / ram_sel / ram_ce
- Accesses are serialised with programmable wait states; the data port has priority.
- Raises a stall request to ctrl until both pending accesses of the current pipeline cycle have completed.

Parameters:
- WAIT_STATES, 2, extra cycles per SRAM access; one access = WAIT_STATES+1 cycles; legal minimum 2.
- ADDR_W, 20, SRAM word-address width; byte address bits [ADDR_W+1:2] are used.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rom_ce_i  in  1  instruction fetch request
- rom_addr_i  in  32  fetch byte address
- rom_data_o  out  32  fetched instruction word
- ram_ce_i  in  1  data access request
- ram_we_i  in  1  1 = write, 0 = read
- ram_sel_i  in  4  byte-lane select for writes
- ram_addr_i  in  32  data byte address
- ram_data_i  in  32  write data
- ram_data_o  out  32  read data, full word
- stallreq_o  out  1  stall request to ctrl
- sram_addr_o  out  ADDR_W  SRAM word address
- sram_data_o  out  32  SRAM write data
- sram_data_oe_o  out  1  enables the top-level tristate driver
- sram_data_i  in  32  SRAM read data
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low strobes
- sram_be_n_o  out  4  active-low byte enables

Behaviour:
- Reset: state IDLE, counter 0, rom_data_o = 0, ram_data_o = 0.
  - sram_addr_o = 0, sram_data_o = 0, sram_data_oe_o = 0.
  - All _n strobes = 1; sram_be_n_o = 4'b1111.
  - rst asserted mid-access aborts immediately and returns to these values.
- States: IDLE, DATA, INST, HOLD. A 2-bit wait counter cnt runs 0..WAIT_STATES.
- IDLE:
  - if ram_ce_i: latch addr/we/sel/wdata, cnt = 0, go DATA;
  - else if rom_ce_i: latch rom_addr_i, go INST;
  - else stay in IDLE.
- DATA:
  - sram_ce_n = 0; address driven from the latch for every cycle of the state.
  - Read: oe_n = 0, be_n = 0000. At cnt = WAIT_STATES, capture sram_data_i into ram_data_o.
  - Write: be_n = ~sel, data_oe = 1 for the whole state. we_n = 0 only for 0 < cnt < WAIT_STATES, so address/data setup and hold are each one cycle.
  - At cnt = WAIT_STATES: go INST if rom_ce_i, else HOLD.
- INST: same as a DATA read, but captures into rom_data_o. At cnt = WAIT_STATES go HOLD.
- HOLD: all strobes inactive; stallreq_o = 0 for exactly one cycle so the pipeline advances; next state IDLE.
- stallreq_o:
  - combinational = (state == IDLE && (rom_ce_i || ram_ce_i)) || state == DATA || state == INST;
  - therefore 0 in HOLD, and 0 in IDLE with no request.
- rom_data_o / ram_data_o hold their last captured value until the next capture of the same port.
- Latency in cycles, stall high throughout except the final cycle:
  - fetch only: 1 + (WAIT_STATES+1) + 1
  - data and fetch: 1 + 2(WAIT_STATES+1) + 1
- Requests are sampled only in IDLE. The core must hold its request inputs stable while stallreq_o = 1. Changes to inputs in other states are ignored.
- ram_sel_i is ignored on reads: a full word is always returned and the mem stage extracts bytes.
- Only one of oe_n / we_n may be low in any cycle; data_oe = 1 implies oe_n = 1. These are bench assertions.
- Address wrap: bits above ADDR_W+1 are dropped silently.

Decomposition:
- defines.v:
  - state encodings `SramIdle, `SramData, `SramInst, `SramHold;
  - `SramAddrBus for the SRAM word-address width;
  - reuse `RegBus for all 32-bit buses.
- One sub-module, sram_access_seq: the counter plus strobe generation for a single access.
  - Inputs: start, we, sel.
  - Outputs: strobes, capture pulse, done.
  - Instantiated once and shared by the DATA and INST states.

Test Plan (all WAIT_STATES = 2):
- Reset then idle: all strobes high, stallreq_o = 0, both read-data outputs 0; rst pulsed mid-DATA returns to this state the next cycle.
- Fetch only (rom_addr_i = 0x0000_0010, SRAM word 4 = 0x2401_0005): stallreq_o high for cycles 0–3, low in cycle 4. sram_addr_o = 4 and oe_n = 0 in cycles 1–3. rom_data_o = 0x2401_0005 from cycle 4.
- Data read plus fetch (ram_addr 0x100 -> 0xDEAD_BEEF; rom_addr 0x14 -> 0x1234_5678): DATA in cycles 1–3, INST in cycles 4–6, stallreq_o falls in cycle 7, both outputs correct.
- Byte write (ram_sel_i = 4'b0010, ram_data_i = 0x0000_AB00, addr 0x200, word initially 0x1111_1111): we_n = 0 only in cycle 2, be_n = 1101. A readback returns 0x1111_AB11.
- Write with no fetch pending: goes DATA -> HOLD, and INST is never entered. oe_n stays 1 and data_oe = 1 throughout DATA.
- Back-to-back requests held over 3 pipeline cycles: exactly one HOLD per cycle, no missing or duplicated SRAM access, and requests are not re-sampled outside IDLE.
